// File: rtl/mult_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mult_pkg : shared types and defaults for the multiplier sequencer  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package mult_pkg;

  localparam int NREQ_DEF = 4;
  localparam int ML_W_DEF = 6;
  localparam int MC_W_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Product of an ML_W-bit and MC_W-bit unsigned value always fits here.
  function automatic int res_w(input int ml_w, input int mc_w);
    return ml_w + mc_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick starting at last_id+1  |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_id,
  output logic            any,
  output logic [IDW-1:0]  winner
);

  logic [IDW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDW'((int'(last_id) + k) % NREQ);
      if (req[cand]) begin
        any    = 1'b1;
        winner = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mult_arbiter : round-robin sharing of a repeated-addition multiply |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
module mult_arbiter
  import mult_pkg::*;
#(
  parameter  int NREQ  = NREQ_DEF,
  parameter  int ML_W  = ML_W_DEF,
  parameter  int MC_W  = MC_W_DEF,
  parameter  int RES_W = res_w(ML_W, MC_W),
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*ML_W-1:0] ml_in,
  input  logic [NREQ*MC_W-1:0] mc_in,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [RES_W-1:0]     result,
  output logic [IDW-1:0]       result_id,
  output logic                 busy
);

  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  state_t          state;
  logic [IDW-1:0]  id;
  logic [IDW-1:0]  last_id;
  logic [ML_W-1:0] ml_q;
  logic [MC_W-1:0] mc_q;
  logic [RES_W-1:0] acc;
  logic [MC_W-1:0] cnt;

  logic            arb_any;
  logic [IDW-1:0]  arb_win;
  logic [ML_W-1:0] ml_arr [NREQ];
  logic [MC_W-1:0] mc_arr [NREQ];
  logic [RES_W-1:0] acc_next;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign ml_arr[i] = ml_in[i*ML_W +: ML_W];
    assign mc_arr[i] = mc_in[i*MC_W +: MC_W];
  end

  assign acc_next = acc + RES_W'(ml_q);

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req     (req),
    .last_id (last_id),
    .any     (arb_any),
    .winner  (arb_win)
  );

  // gnt/done are registered so they are pure functions of the current state and id.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      id        <= '0;
      last_id   <= IDW'(NREQ - 1);
      ml_q      <= '0;
      mc_q      <= '0;
      acc       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      done      <= '0;
      result    <= '0;
      result_id <= '0;
      busy      <= 1'b0;
    end else begin
      gnt  <= '0;
      done <= '0;
      case (state)
        IDLE, DONE: begin
          if (arb_any) begin
            id      <= arb_win;
            last_id <= arb_win;
            ml_q    <= ml_arr[arb_win];
            mc_q    <= mc_arr[arb_win];
            cnt     <= mc_arr[arb_win];
            acc     <= '0;
            gnt     <= ONE << arb_win;
            busy    <= 1'b1;
            state   <= GRANT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        GRANT: begin
          if (mc_q != '0) begin
            state <= RUN;
          end else begin
            result    <= acc;
            result_id <= id;
            done      <= ONE << id;
            state     <= DONE;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt - 1'b1;
          if (cnt == MC_W'(1)) begin
            result    <= acc_next;
            result_id <= id;
            done      <= ONE << id;
            state     <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mult_arbiter : scoreboard bench for mult_arbiter                |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
module tb_mult_arbiter;

  localparam int NREQ  = 4;
  localparam int ML_W  = 6;
  localparam int MC_W  = 2;
  localparam int RES_W = ML_W + MC_W;
  localparam int IDW   = 2;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*ML_W-1:0] ml_in;
  logic [NREQ*MC_W-1:0] mc_in;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      done;
  logic [RES_W-1:0]     result;
  logic [IDW-1:0]       result_id;
  logic                 busy;

  mult_arbiter #(.NREQ(NREQ), .ML_W(ML_W), .MC_W(MC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .ml_in     (ml_in),
    .mc_in     (mc_in),
    .gnt       (gnt),
    .done      (done),
    .result    (result),
    .result_id (result_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int res;
  } exp_t;

  exp_t res_q[$];
  int   gnt_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_done_cyc = -1;
  bit   b2b_en = 1'b0;
  int   eid;
  exp_t e;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Scoreboard monitor: every gnt/done pulse is matched against queued expectations.
  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      if (gnt != '0) begin
        if (gnt_q.size() == 0) begin
          check("gnt_unexpected", 32'(gnt), 32'd0);
        end else begin
          eid = gnt_q.pop_front();
          check("gnt_id", 32'(gnt), 32'(1) << eid);
        end
        if (b2b_en && last_done_cyc >= 0) check("gnt_after_done", 32'(cyc - last_done_cyc), 32'd1);
        if (done != '0) check("gnt_done_overlap", 32'(done), 32'd0);
      end
      if (done != '0) begin
        if (res_q.size() == 0) begin
          check("done_unexpected", 32'(done), 32'd0);
        end else begin
          e = res_q.pop_front();
          check("done_id", 32'(done), 32'(1) << e.id);
          check("result", 32'(result), 32'(e.res));
          check("result_id", 32'(result_id), 32'(e.id));
        end
        last_done_cyc = cyc;
      end
    end
  end

  task automatic set_ops(input int i, input int ml, input int mc);
    ml_in[i*ML_W +: ML_W] = ML_W'(ml);
    mc_in[i*MC_W +: MC_W] = MC_W'(mc);
  endtask

  // Single job: request sampled at E0, gnt expected at E0+1, done at E0+2+mc.
  task automatic run_job(input int i, input int ml, input int mc, input int new_ml);
    int n;
    exp_t x;
    @(negedge clk);
    set_ops(i, ml, mc);
    req[i] = 1'b1;
    x.id  = i;
    x.res = ml * mc;
    res_q.push_back(x);
    gnt_q.push_back(i);
    @(posedge clk);
    #1;
    check("lat_gnt", 32'(gnt), 32'(1) << i);
    check("busy_gnt", 32'(busy), 32'd1);
    req[i] = 1'b0;
    if (new_ml >= 0) set_ops(i, new_ml, mc);
    n = 1;
    while (done == '0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done == '0) check("busy_run", 32'(busy), 32'd1);
    end
    check("lat_done", 32'(n), 32'(mc + 2));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (res_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(res_q.size()), 32'd0);
  endtask

  initial begin
    exp_t x;
    int   n;
    rst   = 1'b1;
    req   = '0;
    ml_in = '0;
    mc_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'({gnt, done, result, result_id, busy}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_job(0, 5, 3, -1);
    check("result_15", 32'(result), 32'd15);
    @(posedge clk);
    #1;
    check("busy_idle", 32'(busy), 32'd0);

    run_job(2, 63, 0, -1);
    check("result_zero", 32'(result), 32'd0);
    run_job(1, 63, 3, -1);
    check("result_189", 32'(result), 32'd189);
    run_job(3, 7, 2, 1);
    check("result_14", 32'(result), 32'd14);
    check("result_id_3", 32'(result_id), 32'd3);

    // All requesters held: expect rotation 0,1,2,3,0 with no idle gap.
    @(negedge clk);
    set_ops(0, 10, 1);
    set_ops(1, 20, 2);
    set_ops(2, 30, 3);
    set_ops(3, 40, 0);
    last_done_cyc = -1;
    b2b_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      x.id  = k % NREQ;
      x.res = (k % NREQ == 0) ? 10 : (k % NREQ == 1) ? 40 : (k % NREQ == 2) ? 90 : 0;
      res_q.push_back(x);
      gnt_q.push_back(k % NREQ);
    end
    req = 4'b1111;
    n = 0;
    while (gnt_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rotation_grants", 32'(gnt_q.size()), 32'd0);
    req = '0;
    drain("rotation_drain");
    b2b_en = 1'b0;
    repeat (2) @(negedge clk);

    // Abort mid-RUN with an asynchronous reset; no done may follow.
    set_ops(0, 5, 3);
    req[0] = 1'b1;
    gnt_q.push_back(0);
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset", 32'({gnt, done, result, result_id, busy}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    set_ops(0, 9, 2);
    set_ops(1, 8, 1);
    set_ops(2, 7, 3);
    set_ops(3, 6, 1);
    x.id  = 0;
    x.res = 18;
    res_q.push_back(x);
    gnt_q.push_back(0);
    req = 4'b1111;
    @(posedge clk);
    #1;
    check("post_reset_gnt", 32'(gnt), 32'd1);
    req = '0;
    drain("post_reset_drain");
    repeat (3) @(negedge clk);
    check("gnt_q_empty", 32'(gnt_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter and sequencer that shares one repeated-addition multiplier among `NREQ` requesters. It grants one requester at a time and captures that requester's operands. It then sequences the accumulate loop, adding `ml` to the accumulator `mc` times, and returns the product with a one-cycle done pulse. It sits between the FSM-level clients and the shared multiply datapath, which is instantiated internally.

## Interface
- `NREQ`, 4: number of requesters; must be 2 or more.
- `ML_W`, 6: multiplier operand width.
- `MC_W`, 2: multiplicand (repeat count) width.
- `RES_W`, `ML_W+MC_W`: derived result width; not overridden.

- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `req`, input, `NREQ`: per-requester request level.
- `ml_in`, input, `NREQ*ML_W`: packed multiplier operands; requester i occupies bits `[i*ML_W +: ML_W]`.
- `mc_in`, input, `NREQ*MC_W`: packed multiplicand operands, packed the same way.
- `gnt`, output, `NREQ`: one-hot grant pulse, 1 cycle.
- `done`, output, `NREQ`: one-hot completion pulse, 1 cycle.
- `result`, output, `RES_W`: product of the last completed job.
- `result_id`, output, `$clog2(NREQ)`: requester index of the last completed job.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: no job active.
  - GRANT: emits `gnt`, 1 cycle.
  - RUN: accumulates, `mc` cycles.
  - DONE: emits `done`, 1 cycle.
- Arbitration is sampled only on edges taken in IDLE or DONE. If any `req` bit is high:
  - the winner is chosen round-robin, searching upward from `last_id+1` and wrapping modulo `NREQ`;
  - `id`, `ml_q` and `mc_q` are captured from the winner's slice;
  - `acc` is set to 0, `cnt` to `mc_q`, and `last_id` to the winner;
  - the next state is GRANT.
- If no `req` bit is high on those edges, the next state is IDLE.
- GRANT: `gnt[id]=1`. Next state is RUN if `mc_q!=0`, else DONE.
- RUN: each edge does `acc<=acc+ml_q` and `cnt<=cnt-1`. When `cnt==1`, the next state is DONE.
- DONE: `done[id]=1`.
  - `result` and `result_id` are loaded on the edge entering DONE and hold until the next DONE.
- Arithmetic is zero-extended to `RES_W` and never overflows. Maximum is 63×3=189 with default widths.
- Requester contract:
  - Hold `req` and the operands stable until `gnt` is seen.
  - Deassert `req` in the cycle after `gnt`. A `req` still high at a later arbitration edge counts as a new request.
  - Operand changes after capture have no effect.
- `gnt` and `done` are Moore decodes of state and `id`, and are never simultaneously high.
- `done` for a job and `gnt` for the next job are on consecutive cycles when the next request is already pending. There is no IDLE bubble.
- Fairness: with all `req` bits held, grants rotate 0,1,…,NREQ-1,0,… and each requester waits at most NREQ−1 jobs.

## Timing
- Reset values:
  - state IDLE; `gnt`, `done`, `result` and `result_id` all 0; `busy` 0;
  - `last_id=NREQ-1`, so requester 0 has top priority after reset;
  - `acc`, `cnt`, `ml_q`, `mc_q` and `id` all 0.
- Reset asserted in any state aborts the job immediately. No `done` is emitted for the aborted job.
- Latency, with the request sampled at edge E0:
  - `gnt` is high in cycle E0+1;
  - `done` is high in cycle E0+2+`mc`;
  - `mc=0` gives `done` in the cycle right after `gnt`.
- Throughput: one job per `mc+2` cycles under continuous load.

## Structure
- Shared package `mult_pkg`:
  - the state enum (IDLE, GRANT, RUN, DONE, 2-bit);
  - default `ML_W`, `MC_W` and `NREQ` constants;
  - a `RES_W` helper function.
- Sub-module `rr_arbiter`:
  - purely combinational; inputs are `req` and `last_id`;
  - outputs are `any` and the winner index;
  - reused by other shared resources.
- The accumulator and counter stay inline in `mult_arbiter`.

## Test plan
- `req[0]` with `ml=5`, `mc=3`, requested at E0 → `gnt=0001` at E0+1, `done=0001` at E0+5, `result=15`, `result_id=0`, `busy` high for cycles E0+1..E0+5.
- `req[2]` with `ml=63`, `mc=0` → `gnt[2]` at E0+1, `done[2]` at E0+2, `result=0`.
- `req[1]` with `ml=63`, `mc=3` → `result=189`, no truncation.
- All `req` held high with distinct operands → grant order 0,1,2,3,0; each `done` is followed directly by the next `gnt`; every `result` matches its `ml×mc`.
- `rst` pulsed mid-RUN → all outputs 0 asynchronously, no `done` for the aborted job; after release, `req=1111` grants requester 0 first.
- After `gnt[3]`, change `ml_in[3]` from 7 to 1 with `mc=2` → `result=14`.
